// File: rtl/winograd_kernel_transform_ctrl.sv
// Purpose : builds the 6x6 Winograd F(4,3) kernel U = G*g*G^T from a 3x3 kernel using one shared 1D transform.
// Latency : the 9th input beat is followed by out_valid 10 cycles later (1 transition + 3 row + 6 column cycles).
// Backpress: in_ready only in LOAD; the output index holds, with stable data, while out_valid & !out_ready.
//
// Ports:
//   clk, rst           rising-edge clock, asynchronous active-high reset
//   clear              synchronous flush back to LOAD (wins over same-cycle handshakes)
//   in_valid/in_ready/in_data     kernel g[r][c] stream, row-major, 9 beats
//   out_valid/out_ready/out_data  result U[i][j] stream, row-major, 36 beats
//   out_last           marks U[5][5]
//   busy               high in ROW, COL and OUT
//   kernel_count       completed-kernel counter, only when WINO_KT_KCOUNT_EN is defined
module winograd_kernel_transform_ctrl #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy
`ifdef WINO_KT_KCOUNT_EN
    ,
    output logic [CNT_W-1:0]  kernel_count
`endif
);

    // A zero-width counter is meaningless; an empty named block documents the constraint.
    if (CNT_W < 1) begin : g_cnt_w_must_be_positive
    end

    typedef enum logic [1:0] {
        S_LOAD,
        S_ROW,
        S_COL,
        S_OUT
    } state_t;

    state_t      state_q, state_d;
    // One index serves every phase: load beat, row r, column j, output beat.
    logic [5:0]  idx_q, idx_d;

    logic [DATA_W-1:0] kbuf_q [9];   // g, row-major
    logic [DATA_W-1:0] tbuf_q [18];  // g*G^T, 3x6 row-major
    logic [DATA_W-1:0] ubuf_q [36];  // U, 6x6 row-major

    logic [DATA_W-1:0] v0, v1, v2;
    logic [DATA_W-1:0] s_p, s_m;
    logic [DATA_W-1:0] t [6];
    logic [3:0]        kbase;
    logic [4:0]        tbase;
    logic [4:0]        col;

    logic in_fire;
    logic out_fire;

    assign in_ready  = (state_q == S_LOAD);
    assign out_valid = (state_q == S_OUT);
    assign busy      = (state_q != S_LOAD);
    assign out_data  = out_valid ? ubuf_q[idx_q] : '0;
    assign out_last  = out_valid && (idx_q == 6'd35);

    assign in_fire  = in_valid && in_ready && !clear;
    assign out_fire = out_valid && out_ready && !clear;

    // Row base offsets into kbuf/tbuf for row r = idx_q during ROW.
    always_comb begin
        kbase = 4'd6;
        tbase = 5'd12;
        case (idx_q[1:0])
            2'd0: begin kbase = 4'd0; tbase = 5'd0; end
            2'd1: begin kbase = 4'd3; tbase = 5'd6; end
            default: begin kbase = 4'd6; tbase = 5'd12; end
        endcase
    end

    assign col = {2'b00, idx_q[2:0]};

    // Shared transform input mux: a kbuf row during ROW, a tbuf column during COL.
    always_comb begin
        v0 = '0;
        v1 = '0;
        v2 = '0;
        if (state_q == S_ROW) begin
            v0 = kbuf_q[kbase];
            v1 = kbuf_q[kbase + 4'd1];
            v2 = kbuf_q[kbase + 4'd2];
        end else if (state_q == S_COL) begin
            v0 = tbuf_q[col];
            v1 = tbuf_q[col + 5'd6];
            v2 = tbuf_q[col + 5'd12];
        end
    end

    // 1D kernel transform; constant multiplies as shift-adds, wrapping modulo 2^DATA_W.
    always_comb begin
        s_p  = v0 + v1 + v2;
        s_m  = v0 - v1 + v2;
        t[0] = (v0 << 2) + (v0 << 1);
        t[1] = -(s_p << 2);
        t[2] = -(s_m << 2);
        t[3] = v0 + (v1 << 1) + (v2 << 2);
        t[4] = v0 - (v1 << 1) + (v2 << 2);
        t[5] = (v2 << 4) + (v2 << 3);
    end

    // Datapath buffers carry no reset: their contents are only read after being written.
    always_ff @(posedge clk) begin
        if (!clear) begin
            case (state_q)
                S_LOAD: begin
                    if (in_valid) begin
                        kbuf_q[idx_q[3:0]] <= in_data;
                    end
                end
                S_ROW: begin
                    for (int k = 0; k < 6; k++) begin
                        tbuf_q[tbase + 5'(k)] <= t[k];
                    end
                end
                S_COL: begin
                    for (int i = 0; i < 6; i++) begin
                        ubuf_q[6'(i * 6) + {1'b0, col}] <= t[i];
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_LOAD;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        if (clear) begin
            state_d = S_LOAD;
            idx_d   = '0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (in_fire) begin
                        if (idx_q == 6'd8) begin
                            state_d = S_ROW;
                            idx_d   = '0;
                        end else begin
                            idx_d = idx_q + 6'd1;
                        end
                    end
                end
                S_ROW: begin
                    if (idx_q == 6'd2) begin
                        state_d = S_COL;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 6'd1;
                    end
                end
                S_COL: begin
                    if (idx_q == 6'd5) begin
                        state_d = S_OUT;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 6'd1;
                    end
                end
                S_OUT: begin
                    if (out_fire) begin
                        if (idx_q == 6'd35) begin
                            state_d = S_LOAD;
                            idx_d   = '0;
                        end else begin
                            idx_d = idx_q + 6'd1;
                        end
                    end
                end
                default: begin
                    state_d = S_LOAD;
                    idx_d   = '0;
                end
            endcase
        end
    end

`ifdef WINO_KT_KCOUNT_EN
    logic [CNT_W-1:0] kcnt_q;

    // Counts kernels fully delivered; a flush does not touch it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kcnt_q <= '0;
        end else if (out_fire && out_last) begin
            kcnt_q <= kcnt_q + 1'b1;
        end
    end

    assign kernel_count = kcnt_q;
`endif

endmodule

// File: tb/tb_winograd_kernel_transform_ctrl.sv
module tb_winograd_kernel_transform_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;
    logic        busy;
`ifdef WINO_KT_KCOUNT_EN
    logic [15:0] kernel_count;
`endif

    winograd_kernel_transform_ctrl #(.DATA_W(32), .CNT_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .clear        (clear),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last     (out_last),
        .busy         (busy)
`ifdef WINO_KT_KCOUNT_EN
        ,
        .kernel_count (kernel_count)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    // G for F(4,3), row-major 6x3.
    int gm [18] = '{6, 0, 0,  -4, -4, -4,  -4, 4, -4,  1, 2, 4,  1, -2, 4,  0, 0, 24};

    bit [31:0] kern [9];
    bit [31:0] expu [36];
    bit [31:0] got  [36];
    bit        gotlast [36];
    int        n_got;
    int        first_edge;
    int        first_acc;
    int        last_acc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model();
        bit [31:0] acc;
        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < 6; j++) begin
                acc = '0;
                for (int r = 0; r < 3; r++)
                    for (int c = 0; c < 3; c++)
                        acc += $unsigned(gm[i*3+r]) * kern[r*3+c] * $unsigned(gm[j*3+c]);
                expu[i*6+j] = acc;
            end
        end
    endtask

    // Feeds the first nb beats of kern; starts and ends #1 after a rising edge.
    task automatic send_kernel(input int nb);
        bit acc;
        for (int b = 0; b < nb; b++) begin
            in_valid = 1'b1;
            in_data  = kern[b];
            acc = 1'b0;
            for (int w = 0; w < 60 && !acc; w++) begin
                acc = in_ready;
                @(posedge clk); #1;
            end
            if (!acc) begin
                chk("in_timeout", 32'd0, 32'd1);
                break;
            end
            if (b == 0) first_acc = cyc;
            if (b == 8) last_acc = cyc;
        end
        in_valid = 1'b0;
    endtask

    // Accepts up to nmax output beats; mode 1 toggles out_ready randomly.
    task automatic collect(input int mode, input int nmax);
        bit        prev_stall = 1'b0;
        bit [31:0] prev_data  = '0;
        bit        prev_last  = 1'b0;
        int        guard = 0;
        n_got = 0;
        first_edge = -1;
        while (n_got < nmax && guard < 600) begin
            out_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid && first_edge < 0) first_edge = cyc + 1;
            if (prev_stall) begin
                chk("stall_data", out_data, prev_data);
                chk("stall_last", 32'(out_last), 32'(prev_last));
            end
            if (out_valid && out_ready) begin
                got[n_got]     = out_data;
                gotlast[n_got] = out_last;
                n_got++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
            @(posedge clk); #1;
            guard++;
        end
        out_ready = 1'b0;
        chk("beats_accepted", 32'(n_got), 32'(nmax));
    endtask

    task automatic check_tail();
        int nl = 0;
        for (int k = 0; k < 36; k++) nl += int'(gotlast[k]);
        chk("last_count", 32'(nl), 32'd1);
        chk("last_at_35", 32'(gotlast[35]), 32'd1);
        chk("done_out_valid", 32'(out_valid), 32'd0);
        chk("done_in_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic check_all(input string pfx);
        for (int k = 0; k < 36; k++)
            chk($sformatf("%s_U%0d%0d", pfx, k / 6, k % 6), got[k], expu[k]);
    endtask

    task automatic check_idle(input string pfx);
        chk({pfx, "_in_ready"}, 32'(in_ready), 32'd1);
        chk({pfx, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({pfx, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic set_kern(input bit [31:0] v00, input bit [31:0] rest);
        for (int b = 0; b < 9; b++) kern[b] = rest;
        kern[0] = v00;
    endtask

    int last_k1;
`ifdef WINO_KT_KCOUNT_EN
    int kc_base;
`endif

    initial begin
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #3;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
`ifdef WINO_KT_KCOUNT_EN
        chk("rst_kcount", 32'(kernel_count), 32'd0);
`endif
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // All-ones kernel: a = [6,-12,-4,7,3,24], U = a_i*a_j.
        set_kern(32'd1, 32'd1);
        model();
        send_kernel(9);
        chk("after9_in_ready", 32'(in_ready), 32'd0);
        chk("after9_busy", 32'(busy), 32'd1);
        collect(0, 36);
        chk("first_valid_latency", 32'(first_edge - last_acc), 32'd10);
        chk("ones_U00", got[0], 32'd36);
        chk("ones_U11", got[7], 32'd144);
        chk("ones_U05", got[5], 32'd144);
        chk("ones_U55", got[35], 32'd576);
        chk("ones_U12", got[8], 32'd48);
        check_tail();
        check_all("ones");

        // Unit impulse at g[0][0]: b = [6,-4,-4,1,1,0].
        set_kern(32'd1, 32'd0);
        model();
        send_kernel(9);
        collect(0, 36);
        chk("imp_U00", got[0], 32'd36);
        chk("imp_U12", got[8], 32'd16);
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("imp_row5_%0d", k), got[30+k], 32'd0);
            chk($sformatf("imp_col5_%0d", k), got[k*6+5], 32'd0);
        end
        check_tail();

        // Modular wrap.
        set_kern(32'h4000_0000, 32'd0);
        send_kernel(9);
        collect(0, 36);
        chk("wrap_U00", got[0], 32'h0000_0000);
        chk("wrap_U03", got[3], 32'h8000_0000);
        chk("wrap_U33", got[21], 32'h4000_0000);
        check_tail();

        // Random kernel with random backpressure.
        for (int b = 0; b < 9; b++) kern[b] = $urandom;
        model();
        send_kernel(9);
        collect(1, 36);
        check_tail();
        check_all("rnd");

`ifdef WINO_KT_KCOUNT_EN
        chk("kcount_4", 32'(kernel_count), 32'd4);
        kc_base = int'(kernel_count);
`endif

        // clear on the 5th input beat.
        set_kern(32'd7, 32'd3);
        send_kernel(4);
        in_valid = 1'b1; in_data = 32'd3; clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0; in_valid = 1'b0;
        check_idle("clr_load");

        // clear during COL: edges 1-3 are ROW, edge 4 lands in COL.
        send_kernel(9);
        repeat (4) @(posedge clk);
        #1;
        chk("pre_clr_col_busy", 32'(busy), 32'd1);
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        check_idle("clr_col");
        repeat (12) @(posedge clk);
        #1;
        chk("clr_col_no_output", 32'(out_valid), 32'd0);

        // clear at output index 20, coincident with an output handshake.
        send_kernel(9);
        collect(0, 20);
        chk("pre_clr_out_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1; clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0; out_ready = 1'b0;
        check_idle("clr_out");

        set_kern(32'd1, 32'd1);
        model();
        send_kernel(9);
        collect(0, 36);
        check_tail();
        check_all("post_clr");
`ifdef WINO_KT_KCOUNT_EN
        chk("kcount_after_clears", 32'(kernel_count), 32'(kc_base + 1));
`endif

        // Async reset in the middle of OUT.
        for (int b = 0; b < 9; b++) kern[b] = $urandom;
        send_kernel(9);
        collect(0, 10);
        rst = 1'b1;
        #1;
        check_idle("arst");
        chk("arst_out_data", out_data, 32'd0);
        chk("arst_out_last", 32'(out_last), 32'd0);
`ifdef WINO_KT_KCOUNT_EN
        chk("arst_kcount", 32'(kernel_count), 32'd0);
`endif
        #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Two back-to-back kernels.
        for (int b = 0; b < 9; b++) kern[b] = $urandom;
        model();
        send_kernel(9);
        last_k1 = last_acc;
        collect(0, 36);
        check_all("b2b1");
        for (int b = 0; b < 9; b++) kern[b] = $urandom;
        model();
        send_kernel(9);
        chk("b2b_gap", 32'(first_acc - last_k1), 32'd46);
        collect(0, 36);
        check_tail();
        check_all("b2b2");
`ifdef WINO_KT_KCOUNT_EN
        chk("kcount_b2b", 32'(kernel_count), 32'd2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
